// File: rtl/vx_stream_rr_arb.sv
// Round-robin merge of NUM_REQS valid/ready streams into one registered output stage.
// With LOCK_PKT=1 a requester keeps the grant until it transfers a beat carrying last_in.
module vx_stream_rr_arb #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 32,
   parameter bit LOCK_PKT = 1'b1,
   localparam int LOGW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       valid_in,
   input  logic [NUM_REQS*DATAW-1:0] data_in,
   input  logic [NUM_REQS-1:0]       last_in,
   output logic [NUM_REQS-1:0]       ready_in,
   output logic                      valid_out,
   output logic [DATAW-1:0]          data_out,
   output logic                      last_out,
   output logic [LOGW-1:0]           sel_out,
   input  logic                      ready_out
);

   logic [LOGW-1:0]  ptr_q, ptr_d;
   logic             locked_q, locked_d;
   logic [LOGW-1:0]  lock_idx_q, lock_idx_d;
   logic             valid_q, valid_d;
   logic [DATAW-1:0] data_q, data_d;
   logic             last_q, last_d;
   logic [LOGW-1:0]  sel_q, sel_d;

   logic [LOGW-1:0]  cand;
   logic [LOGW-1:0]  cand_inc;
   logic [DATAW-1:0] cand_data;
   logic             cand_last;
   logic             search_hit;
   logic             can_load;
   logic             xfer;

   assign can_load = ~valid_q | ready_out;

   // Rotating search as two linear passes: indices at/after ptr first, then the wrapped ones.
   always_comb begin
      cand       = ptr_q;
      search_hit = 1'b0;
      if (locked_q) begin
         cand = lock_idx_q;
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (!search_hit && valid_in[i] && (LOGW'(i) >= ptr_q)) begin
               search_hit = 1'b1;
               cand       = LOGW'(i);
            end
         end
         for (int i = 0; i < NUM_REQS; i++) begin
            if (!search_hit && valid_in[i] && (LOGW'(i) < ptr_q)) begin
               search_hit = 1'b1;
               cand       = LOGW'(i);
            end
         end
      end
   end

   always_comb begin
      cand_data = '0;
      cand_last = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (cand == LOGW'(i)) begin
            cand_data = data_in[i*DATAW +: DATAW];
            cand_last = last_in[i];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
         assign ready_in[gi] = can_load & (cand == LOGW'(gi)) & (locked_q | valid_in[gi]);
      end
   endgenerate

   assign xfer     = |(valid_in & ready_in);
   assign cand_inc = (cand == LOGW'(NUM_REQS - 1)) ? '0 : cand + LOGW'(1);

   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      last_d     = last_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      locked_d   = locked_q;
      lock_idx_d = lock_idx_q;
      if (can_load) begin
         valid_d = xfer;
         if (xfer) begin
            data_d = cand_data;
            last_d = cand_last;
            sel_d  = cand;
         end
      end
      // Mid-packet beats pin the grant; the pointer only advances once the packet closes.
      if (xfer) begin
         if (!LOCK_PKT || cand_last) begin
            ptr_d    = cand_inc;
            locked_d = 1'b0;
         end else begin
            locked_d   = 1'b1;
            lock_idx_d = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q      <= '0;
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         last_q     <= 1'b0;
         sel_q      <= '0;
      end else begin
         ptr_q      <= ptr_d;
         locked_q   <= locked_d;
         lock_idx_q <= lock_idx_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         last_q     <= last_d;
         sel_q      <= sel_d;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign last_out  = last_q;
   assign sel_out   = sel_q;

endmodule

// File: tb/tb_vx_stream_rr_arb.sv
// Directed bench: three arbiter instances (4 streams unlocked, 4 streams locked, 3 streams locked).
module tb_vx_stream_rr_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: NUM_REQS=4, LOCK_PKT=0
   logic [3:0]   a_valid, a_last, a_ready;
   logic [127:0] a_data;
   logic         a_vo, a_lo, a_ro;
   logic [31:0]  a_do;
   logic [1:0]   a_so;
   // Instance B: NUM_REQS=4, LOCK_PKT=1
   logic [3:0]   b_valid, b_last, b_ready;
   logic [127:0] b_data;
   logic         b_vo, b_lo, b_ro;
   logic [31:0]  b_do;
   logic [1:0]   b_so;
   // Instance C: NUM_REQS=3, LOCK_PKT=1
   logic [2:0]   c_valid, c_last, c_ready;
   logic [95:0]  c_data;
   logic         c_vo, c_lo, c_ro;
   logic [31:0]  c_do;
   logic [1:0]   c_so;

   vx_stream_rr_arb #(.NUM_REQS(4), .DATAW(32), .LOCK_PKT(1'b0)) u_dut_a (
      .clk(clk), .reset(rst_n), .valid_in(a_valid), .data_in(a_data), .last_in(a_last),
      .ready_in(a_ready), .valid_out(a_vo), .data_out(a_do), .last_out(a_lo),
      .sel_out(a_so), .ready_out(a_ro));

   vx_stream_rr_arb #(.NUM_REQS(4), .DATAW(32), .LOCK_PKT(1'b1)) u_dut_b (
      .clk(clk), .reset(rst_n), .valid_in(b_valid), .data_in(b_data), .last_in(b_last),
      .ready_in(b_ready), .valid_out(b_vo), .data_out(b_do), .last_out(b_lo),
      .sel_out(b_so), .ready_out(b_ro));

   vx_stream_rr_arb #(.NUM_REQS(3), .DATAW(32), .LOCK_PKT(1'b1)) u_dut_c (
      .clk(clk), .reset(rst_n), .valid_in(c_valid), .data_in(c_data), .last_in(c_last),
      .ready_in(c_ready), .valid_out(c_vo), .data_out(c_do), .last_out(c_lo),
      .sel_out(c_so), .ready_out(c_ro));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   int cnt1, cnt3, exp_sel;
   logic [3:0] fire;

   initial begin
      a_valid = '0; a_last = '0; a_data = '0; a_ro = 1'b1;
      b_valid = '0; b_last = '0; b_data = '0; b_ro = 1'b1;
      c_valid = '0; c_last = '0; c_data = '0; c_ro = 1'b1;

      // Reset with all streams requesting, then plain rotation 0,1,2,3,0
      a_valid = 4'hf;
      a_data  = {32'h103, 32'h102, 32'h101, 32'h100};
      for (int r = 0; r < 2; r++) begin
         step();
         check("rst_valid", a_vo, 0);
         check("rst_sel", a_so, 0);
         check("rst_data", a_do, 0);
         check("rst_ready_in", a_ready, 4'b0001);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("rot_valid", a_vo, 1);
         check("rot_sel", a_so, k % 4);
         check("rot_data", a_do, 32'h100 + (k % 4));
      end

      // Fairness between streams 1 and 3 with per-stream beat counters
      do_reset();
      a_valid = 4'b1010;
      cnt1 = 0; cnt3 = 0;
      for (int k = 0; k < 6; k++) begin
         a_data = {8'd3, 24'(cnt3), 32'h0, 8'd1, 24'(cnt1), 32'h0};
         #1;
         fire    = a_valid & a_ready;
         exp_sel = (k % 2 == 0) ? 1 : 3;
         check("fair_fire", fire, 4'b0001 << exp_sel);
         step();
         check("fair_sel", a_so, exp_sel);
         check("fair_data", a_do, {8'(exp_sel), 24'(k / 2)});
         if (fire[1]) cnt1++;
         if (fire[3]) cnt3++;
      end

      // Backpressure: hold a full output register for 5 cycles
      a_valid = 4'b0001;
      a_data  = {96'h0, 32'hA5A5A5A5};
      step();
      check("bp_load", a_do, 32'hA5A5A5A5);
      a_ro   = 1'b0;
      a_data = {96'h0, 32'h5A5A0001};
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready_in", a_ready, 4'b0000);
         step();
         check("bp_valid", a_vo, 1);
         check("bp_data", a_do, 32'hA5A5A5A5);
         check("bp_sel", a_so, 0);
      end
      a_ro = 1'b1;
      #1;
      check("bp_rel_ready_in", a_ready, 4'b0001);
      step();
      check("bp_next_valid", a_vo, 1);
      check("bp_next_data", a_do, 32'h5A5A0001);
      a_valid = 4'b0000;
      step();
      check("bp_drain", a_vo, 0);

      // Packet lock: warm-up beat moves ptr to 1, then stream 2 sends 3 beats with a gap
      do_reset();
      b_last  = 4'b0001;
      b_valid = 4'b0001;
      b_data  = {32'h0, 32'h0, 32'h0, 32'hF0};
      step();
      check("lk_warm_sel", b_so, 0);
      b_valid = 4'b0101;
      b_data  = {32'h0, 32'h20000001, 32'h0, 32'hF0};
      step();
      check("lk_b1_sel", b_so, 2);
      check("lk_b1_data", b_do, 32'h20000001);
      check("lk_b1_last", b_lo, 0);
      b_valid = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("lk_gap_ready_in", b_ready, 4'b0100);
         step();
         check("lk_gap_valid", b_vo, 0);
      end
      b_valid = 4'b0101;
      b_data  = {32'h0, 32'h20000002, 32'h0, 32'hF0};
      step();
      check("lk_b2_sel", b_so, 2);
      check("lk_b2_data", b_do, 32'h20000002);
      b_last = 4'b0101;
      b_data = {32'h0, 32'h20000003, 32'h0, 32'hF0};
      step();
      check("lk_b3_sel", b_so, 2);
      check("lk_b3_data", b_do, 32'h20000003);
      check("lk_b3_last", b_lo, 1);
      b_valid = 4'b0001;
      step();
      check("lk_after_sel", b_so, 0);
      check("lk_after_data", b_do, 32'hF0);
      b_valid = 4'b0000;

      // Three streams: wrap 0,1,2,0,1 then reset while locked
      do_reset();
      c_valid = 3'b111;
      c_last  = 3'b111;
      c_data  = {32'h302, 32'h301, 32'h300};
      for (int k = 0; k < 5; k++) begin
         step();
         check("wrap_sel", c_so, k % 3);
         check("wrap_data", c_do, 32'h300 + (k % 3));
      end
      c_last = 3'b000;
      step();
      check("wrap_lock_sel", c_so, 2);
      #1;
      check("wrap_lock_ready_in", c_ready, 3'b100);
      rst_n = 1'b0;
      step();
      check("wrap_rst_valid", c_vo, 0);
      check("wrap_rst_sel", c_so, 0);
      check("wrap_rst_ready_in", c_ready, 3'b001);
      rst_n  = 1'b1;
      c_last = 3'b111;
      step();
      check("wrap_restart_sel0", c_so, 0);
      step();
      check("wrap_restart_sel1", c_so, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vx_stream_rr_arb.md
# vx_stream_rr_arb

Round-robin arbiter that merges `NUM_REQS` valid/ready request streams into one registered output stream, with optional packet locking. It sits directly upstream of the skid buffer on shared-resource paths (cache/memory request merge) and drives that buffer's `valid_in`/`data_in`/`ready_in` handshake. It has one output register stage and sustains full throughput.

## Interface
- `NUM_REQS`, 4: number of request streams, ≥1; `LOGW = max(1, clog2(NUM_REQS))`.
- `DATAW`, 32: payload width per stream.
- `LOCK_PKT`, 1: 1 keeps the grant on a requester until it transfers a beat with `last_in`=1; 0 re-arbitrates after every beat.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset (asserted when 0).
- `valid_in`  input  NUM_REQS  per-stream valid.
- `data_in`  input  NUM_REQS*DATAW  payloads; stream i occupies bits [i*DATAW +: DATAW].
- `last_in`  input  NUM_REQS  per-stream end-of-packet flag; ignored when LOCK_PKT=0.
- `ready_in`  output  NUM_REQS  per-stream ready; one-hot or zero.
- `valid_out`  output  1  output beat valid (registered).
- `data_out`  output  DATAW  output payload (registered).
- `last_out`  output  1  copy of the accepted beat's `last_in` (registered).
- `sel_out`  output  LOGW  index of the stream the output beat came from (registered).
- `ready_out`  input  1  downstream ready.

## Operation
- State: priority pointer `ptr` (LOGW bits), `locked` flag, `lock_idx` (LOGW bits), and output register {valid, data, last, sel}.
- `can_load = ~valid_out | ready_out`.
- Grant (combinational): if `locked`, candidate = `lock_idx`; otherwise candidate = the first i with `valid_in[i]`=1, searching ptr, ptr+1, … modulo NUM_REQS.
- `ready_in[i] = can_load & (i == candidate) & (locked | valid_in[i])`. No other stream sees ready. `ready_in` never depends on the other streams' `ready_in`.
- Transfer on stream i: `valid_in[i] & ready_in[i]`. The output register loads data_in[i], last_in[i], and sel=i, and valid becomes 1.
- If `can_load` is 1 and no stream transfers, valid becomes 0 and data/last/sel hold.
- If `can_load` is 0, the whole output register holds. valid_out, data_out, last_out and sel_out are stable while stalled.
- Pointer update on a transfer from i:
  - LOCK_PKT=0: ptr ← (i+1) mod NUM_REQS.
  - LOCK_PKT=1 with last_in[i]=1: ptr ← (i+1) mod NUM_REQS and locked ← 0.
  - LOCK_PKT=1 with last_in[i]=0: locked ← 1, lock_idx ← i, ptr unchanged.
- While locked, other streams are not granted even if the locked stream drops valid (packet gaps stall the arbiter, with no interleaving).
- With NUM_REQS=1 the block degenerates to a pipeline register. ptr stays 0.
- Wrap-around: the search and the pointer increment are modulo NUM_REQS, including non-power-of-2 counts (e.g. NUM_REQS=3: ptr cycles 0→1→2→0).

## Timing
- Reset (reset=0 at an edge): valid_out=0, data_out=0, last_out=0, sel_out=0, ptr=0, locked=0, and ready_in goes to 1 on the stream chosen by the search from 0.
- Reset mid-packet: the lock is cleared, and any held output beat is dropped without being presented.
- Latency: a beat accepted at edge N appears on the outputs after edge N, i.e. 1 cycle.
- Throughput: one beat per cycle when ready_out=1 continuously. Back-to-back grants to different streams are allowed on consecutive cycles.
- Simultaneous pop and load: when valid_out=1 and ready_out=1, a new beat loads in the same cycle with no bubble.
- Full (valid_out=1, ready_out=0): all ready_in=0.
- Empty (valid_out=0): can_load=1 regardless of ready_out.
- ready_in depends combinationally on valid_in, ready_out and state. There is no path from ready_out to valid_out or data_out.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles with valid_in=4'b1111 → valid_out=0, sel_out=0, data_out=0. After release, the first beat out has sel_out=0 and the next cycles give 1, 2, 3, 0 with ready_out=1 and LOCK_PKT=0.
- Fairness: streams 1 and 3 always valid, LOCK_PKT=0, ready_out=1 → sel_out alternates 1, 3, 1, 3. Data matches the per-stream counters with no loss or duplication.
- Backpressure: ready_out=0 for 5 cycles while valid_out=1 with data 0xA5A5A5A5 → outputs hold exactly and ready_in=0. On release, the next beat follows with no bubble.
- Packet lock (LOCK_PKT=1): stream 2 sends 3 beats (last on the third) with a 2-cycle valid gap after beat 1, and stream 0 is always valid → output sel is 2, 2, 2, then 0. Stream 0 stays ungranted during the gap.
- Wrap with NUM_REQS=3: all streams valid → sel sequence 0, 1, 2, 0, 1. Then assert reset mid-lock with LOCK_PKT=1 → valid_out=0 next cycle and arbitration restarts at stream 0.
